// File: rtl/seq_det_sched_if.sv
// Bus bundle for seq_det_sched: per-channel serial bit handshake, channel clears,
// the match pulse and the match-counter read port.
interface seq_det_sched_if #(
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] bit_valid;
  logic [NCH-1:0] bit_data;
  logic [NCH-1:0] bit_ready;
  logic [NCH-1:0] ch_clr;
  logic           match_valid;
  logic [CW-1:0]  match_ch;
  logic [CW-1:0]  cnt_sel;
  logic [7:0]     cnt_out;

  modport master (
    output bit_valid, bit_data, ch_clr, cnt_sel,
    input  bit_ready, match_valid, match_ch, cnt_out
  );

  modport slave (
    input  bit_valid, bit_data, ch_clr, cnt_sel,
    output bit_ready, match_valid, match_ch, cnt_out
  );
endinterface

// File: rtl/seq_det_sched.sv
// Multi-channel serial pattern detector: one shared shift/compare engine is
// time-shared across NCH channel contexts by a round-robin arbiter.
module seq_det_sched #(
  parameter int              NCH     = 4,
  parameter int              PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter bit              OVERLAP = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_sched_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q [NCH];
  logic [FW-1:0]    fill_q [NCH];
  logic [7:0]       mcnt_q [NCH];
  logic [CW-1:0]    rr_q;
  logic [CW-1:0]    mch_q;
  logic             mv_q;

  logic [NCH-1:0]   elig;
  logic             gnt_any;
  logic [CW-1:0]    gnt_idx;
  logic [CW-1:0]    rr_d;
  logic [PAT_W-1:0] hist_sel, hist_d;
  logic [FW-1:0]    fill_sel, fill_d;
  logic             match_d;

  // A channel being cleared this cycle is never offered a grant.
  assign elig = bus.bit_valid & ~bus.ch_clr & {NCH{~rst}};

  // Scan downward in priority so the lowest offset from rr_q is assigned last.
  always_comb begin
    logic [CW:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (CW+1)'(k);
      if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
      if (elig[idx[CW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[CW-1:0];
      end
    end
  end

  assign bus.bit_ready = gnt_any ? (NCH'(1) << gnt_idx) : '0;

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) rr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Shared engine: fetch the granted context, shift in the bit, compare.
  always_comb begin
    hist_sel = hist_q[gnt_idx];
    fill_sel = fill_q[gnt_idx];
    hist_d   = PAT_W'({hist_sel, bus.bit_data[gnt_idx]});
    fill_d   = (fill_sel == FULL) ? FULL : fill_sel + 1'b1;
    match_d  = gnt_any && (fill_d == FULL) && (hist_d == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      mv_q  <= 1'b0;
      mch_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        mcnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      mv_q <= match_d;
      if (match_d) mch_q <= gnt_idx;
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i]) begin
          hist_q[i] <= '0;
          fill_q[i] <= '0;
          mcnt_q[i] <= '0;
        end else if (gnt_any && gnt_idx == CW'(i)) begin
          hist_q[i] <= hist_d;
          // Non-overlapping mode restarts the window; hist is left as is.
          fill_q[i] <= (match_d && !OVERLAP) ? '0 : fill_d;
          if (match_d && mcnt_q[i] != 8'hFF) mcnt_q[i] <= mcnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign bus.match_valid = mv_q;
  assign bus.match_ch    = mch_q;

  always_comb begin
    bus.cnt_out = 8'h00;
    for (int i = 0; i < NCH; i++)
      if (bus.cnt_sel == CW'(i)) bus.cnt_out = mcnt_q[i];
  end
endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: vector tables with expected grants, a scoreboard of
// expected match pulses, and a second OVERLAP=1 instance for overlap behaviour.
module tb_seq_det_sched;
  localparam int NCH = 4;
  localparam int CW  = 2;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] d;
    logic [3:0] clr;
    logic [3:0] rdy;
    bit         m;
    int         ch;
  } vec_t;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t0;

  vec_t tbl[$];
  exp_t sbq[$];
  int   q1[$];
  logic [4:0] p5;
  logic [9:0] p10;
  logic [7:0] p8;

  seq_det_sched_if #(.NCH(NCH)) ifa ();
  seq_det_sched_if #(.NCH(NCH)) ifb ();

  assign ifb.bit_valid = ifa.bit_valid;
  assign ifb.bit_data  = ifa.bit_data;
  assign ifb.ch_clr    = ifa.ch_clr;
  assign ifb.cnt_sel   = ifa.cnt_sel;

  seq_det_sched #(.NCH(NCH), .PAT_W(5), .PATTERN(5'b10110), .OVERLAP(1'b0))
    dut (.clk(clk), .rst(rst), .bus(ifa));
  seq_det_sched #(.NCH(NCH), .PAT_W(5), .PATTERN(5'b10110), .OVERLAP(1'b1))
    dut_ov (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] d,
                              input logic [3:0] clr, input logic [3:0] rdy,
                              input bit m, input int ch);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.clr = clr; x.rdy = rdy; x.m = m; x.ch = ch;
    return x;
  endfunction

  // One cycle: check last edge's match output, drive inputs, check grant.
  task automatic step(input vec_t x);
    @(negedge clk);
    if (ifa.match_valid) begin
      n_cmp++;
      if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
        n_bad++;
        $display("FAIL match_unexpected cyc=%0d got ch=%0d", cyc, ifa.match_ch);
      end else begin
        if (int'(ifa.match_ch) != sbq[0].ch) begin
          n_bad++;
          $display("FAIL match_ch cyc=%0d got %0d want %0d", cyc, ifa.match_ch, sbq[0].ch);
        end
        void'(sbq.pop_front());
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL match_missing cyc=%0d got none want ch=%0d", cyc, sbq[0].ch);
      void'(sbq.pop_front());
    end
    if (ifb.match_valid) q1.push_back(cyc);
    rst           = x.rst;
    ifa.bit_valid = x.v;
    ifa.bit_data  = x.d;
    ifa.ch_clr    = x.clr;
    #1;
    n_cmp++;
    if (ifa.bit_ready !== x.rdy) begin
      n_bad++;
      $display("FAIL bit_ready cyc=%0d got %b want %b", cyc, ifa.bit_ready, x.rdy);
    end
    n_cmp++;
    if (ifb.bit_ready !== x.rdy) begin
      n_bad++;
      $display("FAIL bit_ready_ov cyc=%0d got %b want %b", cyc, ifb.bit_ready, x.rdy);
    end
    if (x.m) sbq.push_back('{ch: x.ch, cyc: cyc + 1});
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic chk_cnt(input logic [CW-1:0] sel, input int exp);
    ifa.cnt_sel = sel;
    #1;
    n_cmp++;
    if (int'(ifa.cnt_out) != exp) begin
      n_bad++;
      $display("FAIL cnt_out sel=%0d got %0d want %0d", sel, ifa.cnt_out, exp);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0));
  endtask

  task automatic add_rst(input int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.bit_valid = '0; ifa.bit_data = '0; ifa.ch_clr = '0; ifa.cnt_sel = '0;
    p5 = 5'b10110; p10 = 10'b1011010110; p8 = 8'b10110110;

    // Reset state: no grants while rst, all outputs and counters zero.
    add_rst(3);
    run_tbl();
    n_cmp++;
    if (ifa.match_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_match_valid got %b want 0", ifa.match_valid);
    end
    n_cmp++;
    if (ifa.match_ch !== 2'd0) begin
      n_bad++; $display("FAIL rst_match_ch got %0d want 0", ifa.match_ch);
    end
    for (int s = 0; s < NCH; s++) chk_cnt(CW'(s), 0);

    // Channel 0 alone, two back-to-back patterns.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1'b0, 4'b0001, {3'b000, p10[9-k]}, 4'h0, 4'b0001, (k == 4 || k == 9), 0));
    add_idle(2);
    run_tbl();
    chk_cnt(0, 2);

    // Shared "10" suffix: one match non-overlapping, two when overlapping.
    add_rst(1);
    run_tbl();
    q1.delete();
    t0 = cyc + 1;
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b0, 4'b0001, {3'b000, p8[7-k]}, 4'h0, 4'b0001, (k == 4), 0));
    add_idle(2);
    run_tbl();
    n_cmp++;
    if (q1.size() != 2) begin
      n_bad++; $display("FAIL overlap_count got %0d want 2", q1.size());
    end else begin
      n_cmp++;
      if (q1[0] != t0 + 5) begin
        n_bad++; $display("FAIL overlap_first got cyc %0d want %0d", q1[0], t0 + 5);
      end
      n_cmp++;
      if (q1[1] != t0 + 8) begin
        n_bad++; $display("FAIL overlap_second got cyc %0d want %0d", q1[1], t0 + 8);
      end
    end

    // All channels valid: strict rotation, channel 2 carries the pattern.
    add_rst(1);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      tbl.push_back(mk(1'b0, 4'hF, {1'b0, p5[4 - k/4], 2'b00}, 4'h0, oh, (k == 18), 2));
    end
    // Clear on the channel rr points to: grant skips to the next one.
    tbl.push_back(mk(1'b0, 4'hF, 4'h0, 4'b0001, 4'b0010, 1'b0, 0));
    tbl.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'b0100, 1'b0, 0));
    add_idle(2);
    run_tbl();
    chk_cnt(2, 1);
    chk_cnt(0, 0);
    chk_cnt(1, 0);

    // Channel 1: partial pattern discarded by ch_clr, pending pulse survives clr.
    add_rst(1);
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b0, 1));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 4'h0, 4'b0010, 1'b0, 1));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b0, 1));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'h0, 4'b0010, 1'b0, 1));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 4'h0, 4'b0010, 1'b0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 4'b0010, {2'b00, p5[4-k], 1'b0}, 4'h0, 4'b0010, (k == 4), 1));
    tbl.push_back(mk(1'b0, 4'h0, 4'h0, 4'b0010, 4'h0, 1'b0, 1));
    add_idle(1);
    run_tbl();
    chk_cnt(1, 0);

    // Channel 3: 260 patterns back to back, counter saturates.
    add_rst(1);
    for (int k = 0; k < 1300; k++)
      tbl.push_back(mk(1'b0, 4'b1000, {p5[4 - (k % 5)], 3'b000}, 4'h0, 4'b1000, (k % 5 == 4), 3));
    add_idle(2);
    run_tbl();
    chk_cnt(3, 255);
    chk_cnt(0, 0);

    // Reset mid-pattern on channel 0 discards the partial match.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, 4'b0001, {3'b000, p5[4-k]}, 4'h0, 4'b0001, 1'b0, 0));
    tbl.push_back(mk(1'b1, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 0));
    tbl.push_back(mk(1'b1, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 0));
    run_tbl();
    n_cmp++;
    if (ifa.match_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_match_valid got %b want 0", ifa.match_valid);
    end
    n_cmp++;
    if (ifa.match_ch !== 2'd0) begin
      n_bad++; $display("FAIL midrst_match_ch got %0d want 0", ifa.match_ch);
    end
    chk_cnt(3, 0);
    tbl.push_back(mk(1'b0, 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 4'b0001, {3'b000, p5[4-k]}, 4'h0, 4'b0001, (k == 4), 0));
    add_idle(2);
    run_tbl();
    chk_cnt(0, 1);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
